// File: rtl/mips_defs.sv
// Shared MIPS pipeline definitions: opcodes, reset PC and the T_new width.
// Also provides the saturating countdown applied to T_new at each stage.
package mips_defs;

  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_LH  = 6'b100001;
  localparam logic [5:0] OP_LHU = 6'b100101;
  localparam logic [5:0] OP_LB  = 6'b100000;
  localparam logic [5:0] OP_LBU = 6'b100100;
  localparam logic [5:0] OP_SW  = 6'b101011;
  localparam logic [5:0] OP_SH  = 6'b101001;
  localparam logic [5:0] OP_SB  = 6'b101000;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;
  localparam int TNEW_W = 2;

  // The count stops at zero once the result is available.
  function automatic logic [TNEW_W-1:0] tnew_dec(input logic [TNEW_W-1:0] t);
    if (t == {TNEW_W{1'b0}}) begin
      return {TNEW_W{1'b0}};
    end else begin
      return t - {{(TNEW_W-1){1'b0}}, 1'b1};
    end
  endfunction

endpackage

// File: rtl/load_extender.sv
// Selects the addressed byte/half of a DM word and sign- or zero-extends it.
// Purely combinational so a later cache stage can reuse it unchanged.
module load_extender
  import mips_defs::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr,
  input  logic [5:0]  opcode,
  output logic [31:0] ext_data
);

  logic [7:0]  byte_s;
  logic [15:0] half_s;

  // Lane selection then extension by load flavour; non-loads yield zero.
  always_comb begin
    byte_s   = rdata[{addr, 3'b000} +: 8];
    half_s   = rdata[{addr[1], 4'b0000} +: 16];
    ext_data = 32'h0000_0000;
    case (opcode)
      OP_LW:   ext_data = rdata;
      OP_LH:   ext_data = {{16{half_s[15]}}, half_s};
      OP_LHU:  ext_data = {16'h0000, half_s};
      OP_LB:   ext_data = {{24{byte_s[7]}}, byte_s};
      OP_LBU:  ext_data = {24'h00_0000, byte_s};
      default: ext_data = 32'h0000_0000;
    endcase
  end

endmodule

// File: rtl/memory_stage.sv
// MIPS M stage: drives the data-memory port, extends load data and holds
// the M/W pipeline register.
module memory_stage
  import mips_defs::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       Instr_M_In,
  input  logic [31:0]       PC_M_In,
  input  logic [4:0]        WriteReg_M_In,
  input  logic [31:0]       ALUOut_M_In,
  input  logic [31:0]       WriteData_M_In,
  input  logic [TNEW_W-1:0] T_new_M_In,
  input  logic [31:0]       m_data_rdata,
  output logic [31:0]       m_data_addr,
  output logic [31:0]       m_data_wdata,
  output logic [3:0]        m_data_byteen,
  output logic [31:0]       m_inst_addr,
  output logic [31:0]       Instr_W_Out,
  output logic [31:0]       PC_W_Out,
  output logic [4:0]        WriteReg_W_Out,
  output logic [31:0]       ALUOut_W_Out,
  output logic [31:0]       DMOut_W_Out,
  output logic [TNEW_W-1:0] T_new_W_Out
);

  logic [5:0]  opcode_s;
  logic [1:0]  lane_s;
  logic [31:0] ext_s;

  assign opcode_s    = Instr_M_In[31:26];
  assign lane_s      = ALUOut_M_In[1:0];
  assign m_data_addr = ALUOut_M_In;
  assign m_inst_addr = PC_M_In;

  load_extender u_load_extender (
    .rdata    (m_data_rdata),
    .addr     (lane_s),
    .opcode   (opcode_s),
    .ext_data (ext_s)
  );

  // Store lane steering; writes are suppressed while reset is held.
  always_comb begin
    m_data_byteen = 4'b0000;
    m_data_wdata  = 32'h0000_0000;
    if (!reset) begin
      m_data_byteen = 4'b0000;
      m_data_wdata  = 32'h0000_0000;
    end else begin
      case (opcode_s)
        OP_SW: begin
          m_data_byteen = 4'b1111;
          m_data_wdata  = WriteData_M_In;
        end
        OP_SH: begin
          m_data_byteen = 4'b0011 << {lane_s[1], 1'b0};
          m_data_wdata  = {2{WriteData_M_In[15:0]}};
        end
        OP_SB: begin
          m_data_byteen = 4'b0001 << lane_s;
          m_data_wdata  = {4{WriteData_M_In[7:0]}};
        end
        default: begin
          m_data_byteen = 4'b0000;
          m_data_wdata  = 32'h0000_0000;
        end
      endcase
    end
  end

  // M/W pipeline register; reset discards the in-flight transfer.
  always_ff @(posedge clk) begin
    if (!reset) begin
      Instr_W_Out    <= 32'h0000_0000;
      PC_W_Out       <= RESET_PC;
      WriteReg_W_Out <= 5'd0;
      ALUOut_W_Out   <= 32'h0000_0000;
      DMOut_W_Out    <= 32'h0000_0000;
      T_new_W_Out    <= {TNEW_W{1'b0}};
    end else begin
      Instr_W_Out    <= Instr_M_In;
      PC_W_Out       <= PC_M_In;
      WriteReg_W_Out <= WriteReg_M_In;
      ALUOut_W_Out   <= ALUOut_M_In;
      DMOut_W_Out    <= ext_s;
      T_new_W_Out    <= tnew_dec(T_new_M_In);
    end
  end

endmodule

// File: tb/tb_memory_stage.sv
// Self-checking bench for memory_stage: directed literal cases plus
// randomized traffic compared every cycle against a behavioural model.
module tb_memory_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] instr, pc, alu, wd, rdata;
  logic [4:0]  wr;
  logic [1:0]  tn;
  logic [31:0] m_data_addr, m_data_wdata, m_inst_addr;
  logic [3:0]  m_data_byteen;
  logic [31:0] instr_w, pc_w, alu_w, dm_w;
  logic [4:0]  wr_w;
  logic [1:0]  tn_w;

  int checks = 0;
  int passes = 0;

  always #5 clk = ~clk;

  memory_stage dut (
    .clk(clk), .reset(reset),
    .Instr_M_In(instr), .PC_M_In(pc), .WriteReg_M_In(wr), .ALUOut_M_In(alu),
    .WriteData_M_In(wd), .T_new_M_In(tn), .m_data_rdata(rdata),
    .m_data_addr(m_data_addr), .m_data_wdata(m_data_wdata),
    .m_data_byteen(m_data_byteen), .m_inst_addr(m_inst_addr),
    .Instr_W_Out(instr_w), .PC_W_Out(pc_w), .WriteReg_W_Out(wr_w),
    .ALUOut_W_Out(alu_w), .DMOut_W_Out(dm_w), .T_new_W_Out(tn_w)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // ---------------- behavioural model ----------------
  function automatic logic [31:0] m_load(input logic [5:0] op, input logic [1:0] a, input logic [31:0] rd);
    logic [7:0]  b;
    logic [15:0] h;
    b = rd[{a, 3'b000} +: 8];
    h = a[1] ? rd[31:16] : rd[15:0];
    case (op)
      6'b100011: return rd;
      6'b100001: return $unsigned(32'($signed(h)));
      6'b100101: return {16'h0000, h};
      6'b100000: return $unsigned(32'($signed(b)));
      6'b100100: return {24'h000000, b};
      default:   return 32'h0;
    endcase
  endfunction

  function automatic logic [3:0] m_byteen(input logic [5:0] op, input logic [1:0] a, input logic rst_n);
    if (!rst_n) return 4'h0;
    case (op)
      6'b101011: return 4'hF;
      6'b101001: return a[1] ? 4'hC : 4'h3;
      6'b101000: return 4'(1 << a);
      default:   return 4'h0;
    endcase
  endfunction

  function automatic logic [31:0] m_wdata(input logic [5:0] op, input logic [31:0] d, input logic rst_n);
    if (!rst_n) return 32'h0;
    case (op)
      6'b101011: return d;
      6'b101001: return d[15:0] * 32'h0001_0001;
      6'b101000: return d[7:0] * 32'h0101_0101;
      default:   return 32'h0;
    endcase
  endfunction

  logic        have_pend = 1'b0;
  logic [31:0] p_instr, p_pc, p_alu, p_dm;
  logic [4:0]  p_wr;
  logic [1:0]  p_tn;

  // Compare process: W outputs vs. prediction from last cycle, DM port vs. current inputs.
  always @(negedge clk) begin
    if (have_pend) begin
      chk("instr_w", instr_w, p_instr);
      chk("pc_w", pc_w, p_pc);
      chk("wr_w", {27'd0, wr_w}, {27'd0, p_wr});
      chk("alu_w", alu_w, p_alu);
      chk("dm_w", dm_w, p_dm);
      chk("tn_w", {30'd0, tn_w}, {30'd0, p_tn});
    end
    chk("addr", m_data_addr, alu);
    chk("inst_addr", m_inst_addr, pc);
    chk("byteen", {28'd0, m_data_byteen}, {28'd0, m_byteen(instr[31:26], alu[1:0], reset)});
    chk("wdata", m_data_wdata, m_wdata(instr[31:26], wd, reset));
    if (!reset) begin
      p_instr = 32'h0; p_pc = 32'h0000_3000; p_wr = 5'd0;
      p_alu = 32'h0; p_dm = 32'h0; p_tn = 2'd0;
    end else begin
      p_instr = instr; p_pc = pc; p_wr = wr; p_alu = alu;
      p_dm = m_load(instr[31:26], alu[1:0], rdata);
      p_tn = (tn == 2'd0) ? 2'd0 : tn - 2'd1;
    end
    have_pend = 1'b1;
  end

  task automatic apply(input logic [31:0] i, input logic [31:0] p, input logic [4:0] w,
                       input logic [31:0] a, input logic [31:0] d, input logic [1:0] t,
                       input logic [31:0] r, input logic rst_n);
    @(posedge clk);
    #1;
    instr = i; pc = p; wr = w; alu = a; wd = d; tn = t; rdata = r; reset = rst_n;
  endtask

  initial begin
    logic [31:0] ops [0:7];
    logic [31:0] ri;
    ops = '{32'h8C00_0000, 32'h8400_0000, 32'h9400_0000, 32'h8000_0000,
            32'h9000_0000, 32'hAC00_0000, 32'hA400_0000, 32'hA000_0000};

    // Reset held for two cycles with a sw in M.
    reset = 1'b0; instr = 32'hAC01_0004; pc = 32'h0000_4000; wr = 5'd3;
    alu = 32'h0000_0010; wd = 32'hDEAD_BEEF; tn = 2'd2; rdata = 32'h1111_2222;
    @(negedge clk);
    chk("rst_byteen", {28'd0, m_data_byteen}, 32'h0);
    @(posedge clk); @(posedge clk); #1;
    chk("rst_instr", instr_w, 32'h0);
    chk("rst_pc", pc_w, 32'h0000_3000);
    chk("rst_alu", alu_w, 32'h0);
    chk("rst_dm", dm_w, 32'h0);
    chk("rst_tn", {30'd0, tn_w}, 32'h0);
    reset = 1'b1;
    @(negedge clk);
    chk("sw_byteen", {28'd0, m_data_byteen}, 32'hF);

    // Store lanes.
    apply(32'hA000_0000, 32'h3000, 5'd0, 32'h0000_0006, 32'h1234_56AB, 2'd0, 32'h0, 1'b1);
    @(negedge clk);
    chk("sb_byteen", {28'd0, m_data_byteen}, 32'h4);
    chk("sb_wdata", m_data_wdata, 32'hABAB_ABAB);
    apply(32'hA400_0000, 32'h3004, 5'd0, 32'h0000_0006, 32'h1234_56AB, 2'd0, 32'h0, 1'b1);
    @(negedge clk);
    chk("sh_byteen", {28'd0, m_data_byteen}, 32'hC);
    chk("sh_wdata", m_data_wdata, 32'h56AB_56AB);

    // Load extension, seen one cycle later.
    apply(32'h8000_0000, 32'h3008, 5'd4, 32'h0000_0002, 32'h0, 2'd1, 32'h80F0_7F01, 1'b1);
    apply(32'h9000_0000, 32'h300C, 5'd4, 32'h0000_0002, 32'h0, 2'd1, 32'h80F0_7F01, 1'b1);
    chk("lb", dm_w, 32'hFFFF_FFF0);
    apply(32'h8400_0000, 32'h3010, 5'd4, 32'h0000_0002, 32'h0, 2'd1, 32'h80F0_7F01, 1'b1);
    chk("lbu", dm_w, 32'h0000_00F0);
    apply(32'h9400_0000, 32'h3014, 5'd4, 32'h0000_0000, 32'h0, 2'd1, 32'h80F0_7F01, 1'b1);
    chk("lh", dm_w, 32'hFFFF_80F0);

    // Pipeline stream addu, lw, nop, jal with a T_new countdown 2,1,0.
    apply(32'h0022_1821, 32'h3018, 5'd3, 32'h0000_0055, 32'h0, 2'd2, 32'hCAFE_F00D, 1'b1);
    chk("lhu", dm_w, 32'h0000_7F01);
    apply(32'h8C25_0000, 32'h301C, 5'd5, 32'h0000_0100, 32'h0, 2'd1, 32'hCAFE_F00D, 1'b1);
    chk("addu_pc", pc_w, 32'h3018);
    chk("addu_alu", alu_w, 32'h0000_0055);
    chk("addu_dm", dm_w, 32'h0);
    chk("tn_2", {30'd0, tn_w}, 32'd1);
    apply(32'h0000_0000, 32'h3020, 5'd0, 32'h0000_0000, 32'h0, 2'd0, 32'h0, 1'b1);
    chk("lw_dm", dm_w, 32'hCAFE_F00D);
    chk("lw_wr", {27'd0, wr_w}, 32'd5);
    chk("tn_1", {30'd0, tn_w}, 32'd0);
    apply(32'h0C00_0C00, 32'h3024, 5'd31, 32'h0000_302C, 32'h0, 2'd0, 32'h0, 1'b1);
    chk("nop_instr", instr_w, 32'h0);
    chk("tn_0", {30'd0, tn_w}, 32'd0);

    // Reset asserted during an active lw.
    apply(32'h8C00_0000, 32'h3028, 5'd7, 32'h0000_0200, 32'h0, 2'd1, 32'h1234_5678, 1'b0);
    chk("jal_instr", instr_w, 32'h0C00_0C00);
    chk("jal_wr", {27'd0, wr_w}, 32'd31);
    @(negedge clk);
    chk("mid_rst_byteen", {28'd0, m_data_byteen}, 32'h0);
    apply(32'h8C00_0000, 32'h302C, 5'd7, 32'h0000_0204, 32'h0, 2'd1, 32'h8765_4321, 1'b1);
    chk("mid_rst_pc", pc_w, 32'h0000_3000);
    chk("mid_rst_dm", dm_w, 32'h0);
    chk("mid_rst_wr", {27'd0, wr_w}, 32'h0);
    apply(32'h0000_0000, 32'h3030, 5'd0, 32'h0, 32'h0, 2'd0, 32'h0, 1'b1);
    chk("resume_dm", dm_w, 32'h8765_4321);

    // Randomized traffic checked by the compare process.
    for (int n = 0; n < 400; n++) begin
      ri = $urandom();
      case ($urandom_range(0, 9))
        8:       ri = 32'h0;
        9:       ri = $urandom();
        default: ri = ops[$urandom_range(0, 7)] | (ri & 32'h03FF_FFFF);
      endcase
      apply(ri, $urandom(), 5'($urandom()), $urandom(), $urandom(), 2'($urandom()),
            $urandom(), ($urandom_range(0, 19) != 0));
    end

    @(negedge clk);
    @(negedge clk);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/memory_stage.md
Name: memory_stage

Overview:
- M stage of the 5-stage MIPS pipeline plus the M/W pipeline register.
- Drives the external data-memory port: address, store data and byte enables.
- Sign/zero-extends load data returned combinationally from the data memory.
- Registers Instr, PC, WriteReg, ALUOut, extended DMOut and a decremented T_new toward the W stage.

Parameters:
- RESET_PC, 32'h0000_3000, value loaded into PC_W_Out on reset.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-low reset
- Instr_M_In  input  32  instruction in M
- PC_M_In  input  32  PC of that instruction
- WriteReg_M_In  input  5  destination register number
- ALUOut_M_In  input  32  ALU result; memory address for loads/stores
- WriteData_M_In  input  32  forwarded rt value for stores
- T_new_M_In  input  2  cycles until the result is produced, as seen in M
- m_data_rdata  input  32  word read from DM at {m_data_addr[31:2],2'b00}
- m_data_addr  output  32  DM byte address
- m_data_wdata  output  32  lane-aligned store data
- m_data_byteen  output  4  byte write enables; 0 means no write
- m_inst_addr  output  32  PC of the instruction in M, for the bench
- Instr_W_Out  output  32  registered instruction to W
- PC_W_Out  output  32  registered PC to W
- WriteReg_W_Out  output  5  registered destination register to W
- ALUOut_W_Out  output  32  registered ALU result to W
- DMOut_W_Out  output  32  registered extended load data to W
- T_new_W_Out  output  2  registered T_new to W

Behaviour:
- Reset (reset==0 at posedge):
  - Instr/WriteReg/ALUOut/DMOut/T_new W outputs all go to 0.
  - PC_W_Out goes to RESET_PC.
  - Reset mid-operation discards the in-flight M->W transfer; nothing is written to the W outputs that cycle.
- Register update: otherwise every posedge copies the M inputs into the W outputs.
  - No stall or flush; bubbles arrive as Instr=0 (nop).
- T_new: T_new_W_Out <= (T_new_M_In==0) ? 0 : T_new_M_In-1; saturates at 0.
- Latency: exactly one cycle M->W for all fields.
- Combinational DM interface:
  - m_data_addr = ALUOut_M_In; m_inst_addr = PC_M_In.
  - Byte lane k = addr[1:0] (lane 0 = bits 7:0); half lane h = addr[1].
- Stores, decoded on opcode Instr_M_In[31:26]:
  - sw 101011: byteen=4'b1111, wdata=WriteData.
  - sh 101001: byteen=4'b0011<<(2*h), wdata={2{WriteData[15:0]}}.
  - sb 101000: byteen=4'b0001<<k, wdata={4{WriteData[7:0]}}.
  - Any other opcode, reset asserted, or Instr=0: byteen=0, wdata=0.
  - Misaligned sw/sh: low address bits are ignored for the aligned lanes; no exception.
- Loads (extension in M, result registered to DMOut_W_Out):
  - lw 100011: rdata.
  - lh 100001 / lhu 100101: half h, sign-/zero-extended.
  - lb 100000 / lbu 100100: byte k, sign-/zero-extended.
  - Non-load opcodes: DMOut_W_Out <= 0.
- Store followed by a load to the same address in the next cycle: the load sees the new data. DM writes at the posedge; this block adds no bypass.

Decomposition:
- Shared package `mips_defs`:
  - opcode localparams (OP_LW, OP_LH, OP_LHU, OP_LB, OP_LBU, OP_SW, OP_SH, OP_SB)
  - RESET_PC default
  - T_new width constant
- One natural sub-module `load_extender`: inputs rdata, addr[1:0], opcode; output 32-bit extended value. It is combinational and reusable by any later cache stage.
- Store-lane logic and the M/W register stay inline.

Test Plan:
- Reset behaviour: hold reset=0 for 2 cycles with Instr_M_In=32'hAC01_0004 (sw) -> m_data_byteen=0 and all W outputs 0 except PC_W_Out=32'h3000. Release reset -> byteen=4'b1111 on the first active cycle.
- Byte store lane: sb with ALUOut=32'h0000_0006, WriteData=32'h1234_56AB -> byteen=4'b0100, wdata=32'hABAB_ABAB. Half store: sh at 32'h...0006 -> byteen=4'b1100, wdata=32'h56AB_56AB.
- Load extension: rdata=32'h80F0_7F01.
  - lb at offset 2 -> DMOut_W_Out=32'hFFFF_FFF0 one cycle later.
  - lbu at offset 2 -> 32'h0000_00F0.
  - lh at offset 2 -> 32'hFFFF_80F0.
  - lhu at offset 0 -> 32'h0000_7F01.
- Pipeline register: drive a 4-instruction stream (addu, lw, nop, jal) with distinct PC/WriteReg/ALUOut -> each appears on the W outputs exactly one cycle later, unchanged. Non-loads show DMOut_W_Out=0.
- T_new countdown: T_new_M_In = 2, 1, 0 on consecutive cycles -> T_new_W_Out = 1, 0, 0 on the following cycles.
- Reset mid-stream: assert reset=0 during an active lw -> next-cycle W outputs are all reset values and byteen=0. Stream resumes cleanly after release.
